// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM port arbiter.
// Master ids, RAM strobe/length widths and the request helper.
package ram_arb_pkg;

    localparam int RAM_STRB_W = 4;
    localparam int RAM_LEN_W  = 8;

    typedef logic mid_t;

    localparam mid_t GNT_M0 = 1'b0;
    localparam mid_t GNT_M1 = 1'b1;

    function automatic logic is_req(
        input logic [RAM_STRB_W-1:0] wr,
        input logic                  rd
    );
        return (|wr) | rd;
    endfunction

endpackage

// File: rtl/ram_port_arb2_if.sv
// Simple pmem-style RAM request/response port.
// The master modport drives requests; the slave modport answers them.
interface ram_port_arb2_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [RAM_STRB_W-1:0] wr;
    logic                  rd;
    logic [RAM_LEN_W-1:0]  len;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     write_data;
    logic                  accept;
    logic                  ack;
    logic                  error;
    logic [DATA_W-1:0]     read_data;

    modport master (
        output wr, rd, len, addr, write_data,
        input  accept, ack, error, read_data
    );

    modport slave (
        input  wr, rd, len, addr, write_data,
        output accept, ack, error, read_data
    );

endinterface

// File: rtl/ram_arb_track_fifo.sv
// Outstanding-request tracker: remembers which master owns each
// accepted-but-unacked RAM request, in issue order.
module ram_arb_track_fifo
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_push,
    input  logic i_pop,
    input  mid_t i_id,
    output logic o_full,
    output logic o_empty,
    output mid_t o_head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_id;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_port_arb2.sv
// Round-robin arbiter sharing one RAM port between two masters.
// Optional burst locking is enabled with RAM_ARB_BURST_LOCK_EN.
module ram_port_arb2
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTSTANDING = 4
) (
    input logic             clk_i,
    input logic             rst_i,
    ram_port_arb2_if.slave  m0,
    ram_port_arb2_if.slave  m1,
    ram_port_arb2_if.master ram
);
    logic [1:0]        w_req;
    mid_t              w_gnt;
    logic              w_gnt_vld;
    logic              w_present;
    logic              w_accept;
    logic              w_full;
    logic              w_empty;
    mid_t              w_head;
    logic              w_pop;
    logic              w_lock;
    mid_t              w_lock_id;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;

    mid_t r_last_grant;
    logic r_hold_valid;
    mid_t r_hold_id;

    assign w_req[0] = is_req(m0.wr, m0.rd);
    assign w_req[1] = is_req(m1.wr, m1.rd);

    always_comb begin
        w_gnt = GNT_M0;
        if (w_lock) begin
            w_gnt = w_lock_id;
        end else if (r_hold_valid) begin
            w_gnt = r_hold_id;
        end else if (&w_req) begin
            w_gnt = ~r_last_grant;
        end else if (w_req[1]) begin
            w_gnt = GNT_M1;
        end
    end

    assign w_gnt_vld = w_req[w_gnt] & ~rst_i;
    assign w_present = w_gnt_vld & ~w_full;
    assign w_accept  = w_present & ram.accept;

    always_comb begin
        ram.wr         = '0;
        ram.rd         = 1'b0;
        ram.len        = '0;
        w_addr         = '0;
        w_wdata        = '0;
        if (w_present) begin
            if (w_gnt == GNT_M1) begin
                ram.wr  = m1.wr;
                ram.rd  = m1.rd;
                ram.len = m1.len;
                w_addr  = m1.addr;
                w_wdata = m1.write_data;
            end else begin
                ram.wr  = m0.wr;
                ram.rd  = m0.rd;
                ram.len = m0.len;
                w_addr  = m0.addr;
                w_wdata = m0.write_data;
            end
        end
    end

    assign ram.addr       = w_addr;
    assign ram.write_data = w_wdata;

    assign m0.accept = w_accept & (w_gnt == GNT_M0);
    assign m1.accept = w_accept & (w_gnt == GNT_M1);

    // Acks with nothing outstanding are dropped here.
    assign w_pop     = ram.ack & ~w_empty;
    assign w_rdata   = ram.read_data;
    assign m0.ack    = w_pop & (w_head == GNT_M0);
    assign m1.ack    = w_pop & (w_head == GNT_M1);
    assign m0.error  = m0.ack & ram.error;
    assign m1.error  = m1.ack & ram.error;
    assign m0.read_data = w_rdata;
    assign m1.read_data = w_rdata;

    ram_arb_track_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_track (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_accept),
        .i_pop   (ram.ack),
        .i_id    (w_gnt),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // A stalled request keeps its grant until the RAM takes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_grant <= GNT_M1;
            r_hold_valid <= 1'b0;
            r_hold_id    <= GNT_M0;
        end else if (w_accept) begin
            r_last_grant <= w_gnt;
            r_hold_valid <= 1'b0;
        end else if (w_present) begin
            r_hold_valid <= 1'b1;
            r_hold_id    <= w_gnt;
        end
    end

`ifdef RAM_ARB_BURST_LOCK_EN
    logic                 r_lock;
    mid_t                 r_lock_id;
    logic [RAM_LEN_W-1:0] r_beat_cnt;
    logic [RAM_LEN_W-1:0] w_len;

    assign w_len     = (w_gnt == GNT_M1) ? m1.len : m0.len;
    assign w_lock    = r_lock;
    assign w_lock_id = r_lock_id;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lock     <= 1'b0;
            r_lock_id  <= GNT_M0;
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            if (r_lock) begin
                r_beat_cnt <= r_beat_cnt - RAM_LEN_W'(1);
                if (r_beat_cnt == RAM_LEN_W'(1)) begin
                    r_lock <= 1'b0;
                end
            end else if (w_len != '0) begin
                r_beat_cnt <= w_len;
                r_lock     <= 1'b1;
                r_lock_id  <= w_gnt;
            end
        end
    end
`else
    assign w_lock    = 1'b0;
    assign w_lock_id = GNT_M0;
`endif

endmodule

// File: tb/tb_ram_port_arb2.sv
// Directed vector bench for ram_port_arb2, plus reset and stall sequences.
// Burst-lock expectations follow RAM_ARB_BURST_LOCK_EN.
module tb_ram_port_arb2;
    import ram_arb_pkg::*;

    localparam int PN = 0;
    localparam int P0 = 1;
    localparam int P1 = 2;

    typedef struct packed {
        logic        acc0;
        logic        acc1;
        logic        ack0;
        logic        ack1;
        logic        err0;
        logic        err1;
        logic        rd;
        logic [3:0]  wr;
        logic [7:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdat0;
        logic [31:0] rdat1;
    } out_t;

    typedef struct {
        logic        rst;
        logic        r0;
        logic [3:0]  w0;
        logic [31:0] a0;
        logic [7:0]  l0;
        logic        r1;
        logic [31:0] a1;
        logic        acc;
        logic        ack;
        logic        err;
        logic [31:0] rdat;
        int          pres;
        logic        ea0;
        logic        ea1;
        logic        ek0;
        logic        ek1;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i;
    int   total = 0;
    int   bad   = 0;
    vec_t vq[$];

    always #5 clk_i = ~clk_i;

    ram_port_arb2_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    ram_port_arb2_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    ram_port_arb2_if #(.ADDR_W(32), .DATA_W(32)) ram_if ();

    ram_port_arb2 #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .OUTSTANDING (4)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .m0    (m0_if),
        .m1    (m1_if),
        .ram   (ram_if)
    );

    task automatic add(
        input logic rst, r0, input logic [3:0] w0,
        input logic [31:0] a0, input logic [7:0] l0,
        input logic r1, input logic [31:0] a1,
        input logic acc, ack, err, input logic [31:0] rdat,
        input int pres, input logic ea0, ea1, ek0, ek1
    );
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.l0 = l0;
        v.r1 = r1; v.a1 = a1; v.acc = acc; v.ack = ack;
        v.err = err; v.rdat = rdat; v.pres = pres;
        v.ea0 = ea0; v.ea1 = ea1; v.ek0 = ek0; v.ek1 = ek1;
        vq.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        rst_i             = v.rst;
        m0_if.rd          = v.r0;
        m0_if.wr          = v.w0;
        m0_if.addr        = v.a0;
        m0_if.len         = v.l0;
        m0_if.write_data  = ~v.a0;
        m1_if.rd          = v.r1;
        m1_if.wr          = 4'h0;
        m1_if.addr        = v.a1;
        m1_if.len         = 8'h00;
        m1_if.write_data  = ~v.a1;
        ram_if.accept     = v.acc;
        ram_if.ack        = v.ack;
        ram_if.error      = v.err;
        ram_if.read_data  = v.rdat;
    endtask

    function automatic out_t expect_of(input vec_t v);
        out_t e;
        e = '0;
        e.acc0  = v.ea0;
        e.acc1  = v.ea1;
        e.ack0  = v.ek0;
        e.ack1  = v.ek1;
        e.err0  = v.ek0 & v.err;
        e.err1  = v.ek1 & v.err;
        e.rdat0 = v.rdat;
        e.rdat1 = v.rdat;
        if (v.pres == P0) begin
            e.rd = v.r0; e.wr = v.w0; e.len = v.l0;
            e.addr = v.a0; e.wdata = ~v.a0;
        end else if (v.pres == P1) begin
            e.rd = v.r1; e.addr = v.a1; e.wdata = ~v.a1;
        end
        return e;
    endfunction

    function automatic out_t sample();
        out_t a;
        a.acc0  = m0_if.accept;
        a.acc1  = m1_if.accept;
        a.ack0  = m0_if.ack;
        a.ack1  = m1_if.ack;
        a.err0  = m0_if.error;
        a.err1  = m1_if.error;
        a.rd    = ram_if.rd;
        a.wr    = ram_if.wr;
        a.len   = ram_if.len;
        a.addr  = ram_if.addr;
        a.wdata = ram_if.write_data;
        a.rdat0 = m0_if.read_data;
        a.rdat1 = m1_if.read_data;
        return a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        out_t a;
        out_t e;
        int   got;

        // rst r0 w0 a0 l0 r1 a1 acc ack err rdat pres ea0 ea1 ek0 ek1
        add(1,1,0,'h100,0, 0,0, 1,0,0,0, PN, 0,0,0,0);
        add(0,1,0,'h100,0, 0,0, 1,0,0,0, P0, 1,0,0,0);
        add(0,0,0,'h100,0, 0,0, 0,0,0,0, PN, 0,0,0,0);
        add(0,0,0,0,0, 0,0, 0,1,0,'hDEADBEEF, PN, 0,0,1,0);
        add(1,0,0,0,0, 0,0, 0,0,0,0, PN, 0,0,0,0);
        add(0,1,0,'h200,0, 1,'h300, 1,0,0,0, P0, 1,0,0,0);
        add(0,1,0,'h200,0, 1,'h300, 1,0,0,0, P1, 0,1,0,0);
        add(0,1,0,'h200,0, 1,'h300, 1,1,0,'h11, P0, 1,0,1,0);
        add(0,1,0,'h200,0, 1,'h300, 1,1,0,'h22, P1, 0,1,0,1);
        add(0,0,0,0,0, 0,0, 0,1,0,'h33, PN, 0,0,1,0);
        add(0,0,0,0,0, 0,0, 0,1,1,'h44, PN, 0,0,0,1);
        add(0,0,0,0,0, 0,0, 0,1,1,'h55, PN, 0,0,0,0);
        add(0,0,0,0,0, 1,'h300, 0,0,0,0, P1, 0,0,0,0);
        add(0,1,0,'h200,0, 1,'h300, 0,0,0,0, P1, 0,0,0,0);
        add(0,1,0,'h200,0, 1,'h300, 0,0,0,0, P1, 0,0,0,0);
        add(0,1,0,'h200,0, 1,'h300, 1,0,0,0, P1, 0,1,0,0);
        add(0,1,0,'h200,0, 1,'h300, 1,0,0,0, P0, 1,0,0,0);
        add(0,0,0,0,0, 0,0, 0,1,0,0, PN, 0,0,0,1);
        add(0,0,0,0,0, 0,0, 0,1,0,0, PN, 0,0,1,0);
        add(0,0,4'hF,'h400,2, 0,0, 1,0,0,0, P0, 1,0,0,0);
        add(0,0,4'hF,'h404,2, 0,0, 1,0,0,0, P0, 1,0,0,0);
        add(0,1,0,'h408,2, 0,0, 1,0,0,0, P0, 1,0,0,0);
        add(0,1,0,'h40C,0, 0,0, 1,0,0,0, P0, 1,0,0,0);
        add(0,1,0,'h410,0, 0,0, 1,0,0,0, PN, 0,0,0,0);
        add(0,1,0,'h410,0, 0,0, 1,1,0,0, PN, 0,0,1,0);
        add(0,1,0,'h410,0, 0,0, 1,0,0,0, P0, 1,0,0,0);
        add(0,0,0,0,0, 0,0, 0,1,0,0, PN, 0,0,1,0);
        add(0,0,0,0,0, 0,0, 0,1,0,0, PN, 0,0,1,0);
        add(0,0,0,0,0, 0,0, 0,1,0,0, PN, 0,0,1,0);
        add(0,0,0,0,0, 0,0, 0,1,0,0, PN, 0,0,1,0);
        add(0,0,0,0,0, 0,0, 0,1,0,0, PN, 0,0,0,0);
        add(1,0,0,0,0, 0,0, 0,0,0,0, PN, 0,0,0,0);
        add(0,1,0,'h200,3, 1,'h300, 1,0,0,0, P0, 1,0,0,0);
`ifdef RAM_ARB_BURST_LOCK_EN
        add(0,1,0,'h200,3, 1,'h300, 1,0,0,0, P0, 1,0,0,0);
        add(0,1,0,'h200,3, 1,'h300, 1,1,0,0, P0, 1,0,1,0);
        add(0,1,0,'h200,3, 1,'h300, 1,1,0,0, P0, 1,0,1,0);
        add(0,1,0,'h200,3, 1,'h300, 1,1,0,0, P1, 0,1,1,0);
        add(0,0,0,0,0, 0,0, 0,1,0,0, PN, 0,0,1,0);
        add(0,0,0,0,0, 0,0, 0,1,0,0, PN, 0,0,0,1);
`else
        add(0,1,0,'h200,3, 1,'h300, 1,0,0,0, P1, 0,1,0,0);
        add(0,1,0,'h200,3, 1,'h300, 1,1,0,0, P0, 1,0,1,0);
        add(0,1,0,'h200,3, 1,'h300, 1,1,0,0, P1, 0,1,0,1);
        add(0,1,0,'h200,3, 1,'h300, 1,1,0,0, P0, 1,0,1,0);
        add(0,0,0,0,0, 0,0, 0,1,0,0, PN, 0,0,0,1);
        add(0,0,0,0,0, 0,0, 0,1,0,0, PN, 0,0,1,0);
`endif

        apply(vq[0]);
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk_i);
            #1;
            apply(vq[i]);
            #2;
            a = sample();
            e = expect_of(vq[i]);
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL vec%0d: got %h want %h", i, a, e);
            end
        end

        // Reset mid-operation drops acks for earlier requests.
        @(posedge clk_i);
        #1;
        apply(vq[4]);
        rst_i = 1'b0;
        m0_if.rd = 1'b1;
        m0_if.addr = 32'h500;
        ram_if.accept = 1'b1;
        #2;
        chk("rmid_acc_a", 32'(m0_if.accept), 1);
        @(posedge clk_i);
        #3;
        chk("rmid_acc_b", 32'(m0_if.accept), 1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        chk("rmid_rd", 32'(ram_if.rd), 0);
        chk("rmid_acc", 32'(m0_if.accept), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m0_if.rd = 1'b0;
        ram_if.accept = 1'b0;
        ram_if.ack = 1'b1;
        #2;
        chk("rmid_drop", 32'({m0_if.ack, m1_if.ack}), 0);

        // Stalled m1 keeps its grant; accept appears when RAM is ready.
        got = -1;
        @(posedge clk_i);
        #1;
        ram_if.ack = 1'b0;
        m1_if.rd = 1'b1;
        m1_if.addr = 32'h600;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                @(posedge clk_i);
                #1;
            end
            m0_if.rd = (c >= 1);
            ram_if.accept = (c >= 3);
            #2;
            if (m0_if.accept) begin
                got = 100 + c;
            end
            if (m1_if.accept && got < 0) begin
                got = c;
                break;
            end
        end
        chk("m1_stall_wait", 32'(got), 3);
        chk("m1_stall_addr", ram_if.addr, 32'h600);
        @(posedge clk_i);
        #1;
        m1_if.rd = 1'b0;
        #2;
        chk("m0_next", 32'(m0_if.accept), 1);
        @(posedge clk_i);
        #1;
        m0_if.rd = 1'b0;
        ram_if.accept = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
